cmos_axi4s_frame_ctrl: RTL

Frame-sync and integrity controller between the CMOS native-video-to-AXI4-Stream bridge and downstream video consumers (VDMA, processing IP). It keeps output frames intact: it drops stream data until a start-of-frame and checks every line and frame against the configured geometry. On a geometry error or a FIFO overflow it truncates the frame cleanly and resynchronises on the next SOF. It also reports lock and error status for software.

---
 rtl/cmos_axi4s_frame_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cmos_axi4s_frame_ctrl.sv
// Frame-sync and integrity gate between the CMOS-to-AXI4-Stream bridge and video consumers.
// Drops data until SOF, checks line/frame geometry, truncates and resyncs on errors.
module cmos_axi4s_frame_ctrl #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              fifo_overflow,
  input  logic [DATA_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  output logic              s_axis_video_tready,
  input  logic              s_axis_video_tuser,
  input  logic              s_axis_video_tlast,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
  output logic              locked,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt,
  output logic [2:0]        last_err
);

  typedef enum logic [1:0] {IDLE, SYNC, STREAM} state_t;

  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);

  state_t           state;
  logic [CNT_W-1:0] pix;
  logic [CNT_W-1:0] line;
  logic [3:0]       good_cnt;
  logic [3:0]       good_next;
  logic             at_sof;
  logic             in_stream;
  logic             pass;
  logic             acc;
  logic             pix_end;
  logic [2:0]       err_code;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc_lock(input logic [3:0] v);
    return (v < LOCK_N) ? v + 4'd1 : v;
  endfunction

  assign at_sof    = (pix == '0) && (line == '0);
  assign in_stream = (state == STREAM);
  assign pix_end   = (pix == PIX_LAST);

  // A beat passes once inside a frame, or when it carries SOF while hunting for a frame start.
  assign pass = (in_stream && !at_sof) || ((state != IDLE) && s_axis_video_tuser);

  assign s_axis_video_tready = pass ? m_axis_video_tready : 1'b1;
  assign m_axis_video_tvalid = pass & s_axis_video_tvalid;
  assign m_axis_video_tdata  = s_axis_video_tdata;
  assign m_axis_video_tuser  = s_axis_video_tuser;
  assign m_axis_video_tlast  = s_axis_video_tlast | (in_stream & pix_end);
  assign acc                 = s_axis_video_tvalid & s_axis_video_tready;
  assign good_next           = sat_inc_lock(good_cnt);

  // Overflow outranks any beat-level geometry error in the same cycle.
  always_comb begin
    err_code = 3'd0;
    if ((state != IDLE) && fifo_overflow) begin
      err_code = 3'd4;
    end else if (in_stream && acc) begin
      if (s_axis_video_tuser && !at_sof)       err_code = 3'd1;
      else if (!s_axis_video_tuser && at_sof)  err_code = 3'd5;
      else if (s_axis_video_tlast && !pix_end) err_code = 3'd2;
      else if (!s_axis_video_tlast && pix_end) err_code = 3'd3;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      pix       <= '0;
      line      <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      last_err  <= '0;
      locked    <= 1'b0;
      good_cnt  <= '0;
    end else if (err_code != 3'd0) begin
      err_cnt  <= sat_inc8(err_cnt);
      last_err <= err_code;
      good_cnt <= '0;
      locked   <= 1'b0;
      line     <= '0;
      // Early SOF restarts the frame in place; every other error resyncs.
      if (err_code == 3'd1) begin
        pix <= CNT_ONE;
      end else begin
        state <= SYNC;
        pix   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SYNC;
            pix   <= '0;
            line  <= '0;
          end
        end
        SYNC: begin
          if (!enable) begin
            state <= IDLE;
          end else if (acc && s_axis_video_tuser) begin
            state <= STREAM;
            pix   <= CNT_ONE;
            line  <= '0;
          end
        end
        STREAM: begin
          if (acc) begin
            if (pix_end) begin
              pix <= '0;
              if (line == LINE_LAST) begin
                line      <= '0;
                frame_cnt <= frame_cnt + 16'd1;
                good_cnt  <= good_next;
                locked    <= (good_next == LOCK_N);
                if (!enable) state <= IDLE;
              end else begin
                line <= line + CNT_ONE;
              end
            end else begin
              pix <= pix + CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
